// File: rtl/fir4_cla_u.sv
// rtl/fir4_cla_u.sv - 4-tap unity-coefficient signed FIR, tree of carry-lookahead adders
// Delay line ar..dr feeds (ar+br)+(cr+dr) combinationally into the registered sum s.

module fir4_cla_u_cla #(
   parameter int N = 17
) (
   input  logic [N-1:0] x_i,
   input  logic [N-1:0] y_i,
   output logic [N-1:0] sum_o
);
   localparam int NG = (N + 3) / 4;

   logic [N-1:0]  g;
   logic [N-1:0]  p;
   logic [N-1:0]  c;
   logic [NG-1:0] gc;
   logic          grp_g;
   logic          grp_p;
   logic          term;
   int            idx;

   always_comb begin
      g     = x_i & y_i;
      p     = x_i ^ y_i;
      c     = '0;
      gc    = '0;
      grp_g = 1'b0;
      grp_p = 1'b0;
      term  = 1'b0;
      idx   = 0;
      for (int k = 0; k < NG; k++) begin
         // Group carry-in from the previous (always full) group's G/P.
         if (k > 0) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
               term = g[4*(k-1)+j];
               for (int m = j + 1; m < 4; m++) term &= p[4*(k-1)+m];
               grp_g |= term;
               grp_p &= p[4*(k-1)+j];
            end
            gc[k] = grp_g | (grp_p & gc[k-1]);
         end
         // Flattened in-group carries; the last group may be partial.
         for (int j = 0; j < 4; j++) begin
            idx = 4 * k + j;
            if (idx < N) begin
               term = gc[k];
               for (int m = 0; m < j; m++) term &= p[4*k+m];
               c[idx] = term;
               for (int b = 0; b < j; b++) begin
                  term = g[4*k+b];
                  for (int m = b + 1; m < j; m++) term &= p[4*k+m];
                  c[idx] = c[idx] | term;
               end
            end
         end
      end
      sum_o = p ^ c;
   end
endmodule

module fir4_cla_u #(
   parameter int w = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [w-1:0] a,
   output logic [w+1:0] s
);
   logic [w-1:0] ar_q, br_q, cr_q, dr_q;
   logic [w:0]   ab_sum, cd_sum;
   logic [w+1:0] s_d, s_q;

   fir4_cla_u_cla #(.N(w + 1)) u_add_ab (
      .x_i   ({ar_q[w-1], ar_q}),
      .y_i   ({br_q[w-1], br_q}),
      .sum_o (ab_sum)
   );

   fir4_cla_u_cla #(.N(w + 1)) u_add_cd (
      .x_i   ({cr_q[w-1], cr_q}),
      .y_i   ({dr_q[w-1], dr_q}),
      .sum_o (cd_sum)
   );

   fir4_cla_u_cla #(.N(w + 2)) u_add_fin (
      .x_i   ({ab_sum[w], ab_sum}),
      .y_i   ({cd_sum[w], cd_sum}),
      .sum_o (s_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ar_q <= '0;
         br_q <= '0;
         cr_q <= '0;
         dr_q <= '0;
         s_q  <= '0;
      end else begin
         ar_q <= a;
         br_q <= ar_q;
         cr_q <= br_q;
         dr_q <= cr_q;
         s_q  <= s_d;
      end
   end

   assign s = s_q;
endmodule

// File: tb/tb_fir4_cla_u.sv
// tb/tb_fir4_cla_u.sv - table-driven and scoreboard bench for fir4_cla_u at w=16, 8, 32
module tb_fir4_cla_u;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] a16;
   logic [17:0] s16;
   logic [7:0]  a8;
   logic [9:0]  s8;
   logic [31:0] a32;
   logic [33:0] s32;

   always #5 clk = ~clk;

   fir4_cla_u #(.w(16)) dut16 (.clk(clk), .reset(reset), .a(a16), .s(s16));
   fir4_cla_u #(.w(8))  dut8  (.clk(clk), .reset(reset), .a(a8),  .s(s8));
   fir4_cla_u #(.w(32)) dut32 (.clk(clk), .reset(reset), .a(a32), .s(s32));

   typedef struct {
      bit          rst;
      logic [15:0] a;
      int          exp;
      string       name;
   } vec_t;

   vec_t   vecs[$];
   longint q16[$], q8[$], q32[$];
   longint h16[4], h8[4], h32[4];
   int     n_checks = 0;
   int     n_pass = 0;

   function automatic void add(bit r, logic [15:0] av, int e, string n);
      vec_t v;
      v.rst = r; v.a = av; v.exp = e; v.name = n;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, longint act, longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(bit r, logic [15:0] av, int tbl_exp, bit use_tbl, string name);
      logic [7:0]  r8  = 8'($urandom);
      logic [31:0] r32 = $urandom;
      longint e16 = 0, e8 = 0, e32 = 0;
      reset = r; a16 = av; a8 = r8; a32 = r32;
      if (r) begin
         for (int i = 0; i < 4; i++) begin h16[i] = 0; h8[i] = 0; h32[i] = 0; end
      end else begin
         for (int i = 0; i < 4; i++) begin e16 += h16[i]; e8 += h8[i]; e32 += h32[i]; end
         for (int i = 3; i > 0; i--) begin h16[i] = h16[i-1]; h8[i] = h8[i-1]; h32[i] = h32[i-1]; end
         h16[0] = longint'($signed(av));
         h8[0]  = longint'($signed(r8));
         h32[0] = longint'($signed(r32));
      end
      q16.push_back(use_tbl ? longint'(tbl_exp) : e16);
      q8.push_back(e8);
      q32.push_back(e32);
      @(posedge clk);
      @(negedge clk);
      check(name, longint'($signed(s16)), q16.pop_front());
      check({name, "_w8"}, longint'($signed(s8)), q8.pop_front());
      check({name, "_w32"}, longint'($signed(s32)), q32.pop_front());
   endtask

   initial begin
      reset = 1'b1; a16 = '0; a8 = '0; a32 = '0;
      @(negedge clk);

      add(1, 16'h1234, 0, "reset0");
      add(1, 16'h1234, 0, "reset1");
      add(0, 16'h0001, 0, "imp0");
      add(0, 16'h0000, 1, "imp1");
      add(0, 16'h0000, 1, "imp2");
      add(0, 16'h0000, 1, "imp3");
      add(0, 16'h0000, 1, "imp4");
      add(0, 16'h0000, 0, "imp5");
      add(0, 16'h7FFF, 0, "maxp0");
      add(0, 16'h7FFF, 32767, "maxp1");
      add(0, 16'h7FFF, 65534, "maxp2");
      add(0, 16'h7FFF, 98301, "maxp3");
      add(0, 16'h7FFF, 131068, "maxp4");
      add(0, 16'h7FFF, 131068, "maxp5");
      add(0, 16'h8000, 131068, "maxn0");
      add(0, 16'h8000, 65533, "maxn1");
      add(0, 16'h8000, -2, "maxn2");
      add(0, 16'h8000, -65537, "maxn3");
      add(0, 16'h8000, -131072, "maxn4");
      add(0, 16'h8000, -131072, "maxn5");
      add(0, 16'h7FFF, -131072, "alt0");
      add(0, 16'h8000, -65537, "alt1");
      add(0, 16'h7FFF, -65537, "alt2");
      add(0, 16'h8000, -2, "alt3");
      add(0, 16'h7FFF, -2, "alt4");
      add(0, 16'h8000, -2, "alt5");
      add(0, 16'd100, -2, "mid0");
      add(0, 16'd100, -32669, "mid1");
      add(0, 16'd100, 199, "mid2");
      add(0, 16'd100, -32468, "mid3");
      add(1, 16'd100, 0, "mid_rst");
      add(0, 16'd5, 0, "post0");
      add(0, 16'd5, 5, "post1");
      add(0, 16'd5, 10, "post2");
      add(0, 16'd5, 15, "post3");
      add(0, 16'd5, 20, "post4");

      foreach (vecs[i]) step(vecs[i].rst, vecs[i].a, vecs[i].exp, 1'b1, vecs[i].name);

      for (int i = 0; i < 30; i++) step(1'b0, 16'($urandom), 0, 1'b0, $sformatf("rand%0d", i));
      step(1'b1, 16'h7FFF, 0, 1'b0, "rand_rst");
      for (int i = 0; i < 6; i++) step(1'b0, 16'($urandom), 0, 1'b0, $sformatf("rand_post%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
